// File: rtl/channel_norm_scheduler.sv
// channel_norm_scheduler: sequences the block stream into the per-channel statistics
// accumulator and hands each completed channel to the finalize unit.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream block handshake
//   acc_valid / acc_ready accumulator handshake (combinational pass-through in ACCUM)
//   acc_first / acc_last  current block is spatial index 0 / last of its channel
//   channel               channel of the current block or finalize request
//   fin_valid / fin_ready finalize request handshake
//   fin_done              finalize completion pulse
//   frame_done            one-cycle pulse after the last channel of a frame is finalized
//   busy                  scheduler is anywhere but the idle start-of-frame point
module channel_norm_scheduler #(
    parameter int NUM_CHANNELS = 2,
    parameter int NUM_SPATIAL_BLOCKS = 4,
    localparam int C_STATE_WIDTH = (NUM_CHANNELS == 1) ? 1 : $clog2(NUM_CHANNELS),
    localparam int S_STATE_WIDTH = (NUM_SPATIAL_BLOCKS == 1) ? 1 : $clog2(NUM_SPATIAL_BLOCKS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic                     acc_first,
    output logic                     acc_last,
    output logic [C_STATE_WIDTH-1:0] channel,
    output logic                     fin_valid,
    input  logic                     fin_ready,
    input  logic                     fin_done,
    output logic                     frame_done,
    output logic                     busy
);
    typedef enum logic [1:0] {ACCUM, FIN_REQ, FIN_WAIT} state_e;
    localparam logic [C_STATE_WIDTH-1:0] C_LAST = C_STATE_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [S_STATE_WIDTH-1:0] S_LAST = S_STATE_WIDTH'(NUM_SPATIAL_BLOCKS - 1);
    state_e                   state_q, state_d;
    logic [C_STATE_WIDTH-1:0] ch_q, ch_d;
    logic [S_STATE_WIDTH-1:0] sp_q, sp_d;
    logic                     frame_done_q, frame_done_d;
    logic                     xfer, complete, sp_last, ch_last;
    assign sp_last   = sp_q == S_LAST;
    assign ch_last   = ch_q == C_LAST;
    assign xfer      = state_q == ACCUM && in_valid && acc_ready;
    // A request accepted together with its done pulse completes without visiting FIN_WAIT.
    assign complete  = fin_done && ((state_q == FIN_REQ && fin_ready) || state_q == FIN_WAIT);
    assign acc_valid = state_q == ACCUM && in_valid;
    assign in_ready  = state_q == ACCUM && acc_ready;
    assign fin_valid = state_q == FIN_REQ;
    assign acc_first = sp_q == '0;
    assign acc_last  = sp_last;
    assign channel   = ch_q;
    assign frame_done = frame_done_q;
    assign busy      = state_q != ACCUM || sp_q != '0 || ch_q != '0;
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        sp_d         = sp_q;
        frame_done_d = 1'b0;
        if (xfer) begin
            sp_d    = sp_last ? '0 : sp_q + S_STATE_WIDTH'(1);
            state_d = sp_last ? FIN_REQ : ACCUM;
        end
        if (state_q == FIN_REQ && fin_ready && !fin_done) state_d = FIN_WAIT;
        if (complete) begin
            ch_d         = ch_last ? '0 : ch_q + C_STATE_WIDTH'(1);
            frame_done_d = ch_last;
            state_d      = ACCUM;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ACCUM;
            ch_q         <= '0;
            sp_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            sp_q         <= sp_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_channel_norm_scheduler.sv
// tb_channel_norm_scheduler: scoreboard bench for channel_norm_scheduler (2x4 and 3x1 instances).
module tb_channel_norm_scheduler;
    typedef struct packed {
        logic [1:0] ch;
        logic       first;
        logic       last;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, acc_ready, fin_ready, fin_done;
    logic       in_ready, acc_valid, acc_first, acc_last, fin_valid, frame_done, busy;
    logic [0:0] channel;
    logic       b_in_valid, b_acc_ready, b_fin_ready, b_fin_done;
    logic       b_in_ready, b_acc_valid, b_acc_first, b_acc_last, b_fin_valid, b_frame_done, b_busy;
    logic [1:0] b_channel;

    int    n_vec = 0;
    int    n_err = 0;
    xfer_t exp_q[$];
    int    fin_q[$];

    channel_norm_scheduler #(.NUM_CHANNELS(2), .NUM_SPATIAL_BLOCKS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_first(acc_first),
        .acc_last(acc_last), .channel(channel), .fin_valid(fin_valid),
        .fin_ready(fin_ready), .fin_done(fin_done), .frame_done(frame_done), .busy(busy)
    );

    channel_norm_scheduler #(.NUM_CHANNELS(3), .NUM_SPATIAL_BLOCKS(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .acc_valid(b_acc_valid), .acc_ready(b_acc_ready), .acc_first(b_acc_first),
        .acc_last(b_acc_last), .channel(b_channel), .fin_valid(b_fin_valid),
        .fin_ready(b_fin_ready), .fin_done(b_fin_done), .frame_done(b_frame_done), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic iv, input logic ar, input logic fr, input logic fd);
        @(posedge clk);
        #1;
        in_valid  = iv;
        acc_ready = ar;
        fin_ready = fr;
        fin_done  = fd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        {in_valid, acc_ready, fin_ready, fin_done} = '0;
        {b_in_valid, b_acc_ready, b_fin_ready, b_fin_done} = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        acc_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (channel !== 1'b0)  begin n_err++; $display("FAIL reset_channel got %0d want 0", channel); end
        n_vec++; if (acc_first !== 1'b1) begin n_err++; $display("FAIL reset_acc_first got %b want 1", acc_first); end
        n_vec++; if (acc_last !== 1'b0) begin n_err++; $display("FAIL reset_acc_last got %b want 0", acc_last); end
        n_vec++; if (fin_valid !== 1'b0) begin n_err++; $display("FAIL reset_fin_valid got %b want 0", fin_valid); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL reset_acc_valid got %b want 0", acc_valid); end
        n_vec++; if (b_acc_last !== 1'b1) begin n_err++; $display("FAIL reset_b_acc_last got %b want 1", b_acc_last); end
    endtask

    // Drives one whole 2x4 frame; phase 0/1/2 = accumulate / request pending / waiting for done.
    task automatic run_frame(input string name, input bit rand_bp, input int fin_lat, input int fin_stall);
        int    phase = 0, phase_n, stall = 0, cd = 0, frames = 0, cyc = 0, cur = 0;
        bit    fd_exp = 0, fd_next;
        xfer_t e;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 4; s++) exp_q.push_back('{ch: 2'(c), first: (s == 0), last: (s == 3)});
            fin_q.push_back(c);
        end
        while ((frames < 1 || exp_q.size() != 0 || fd_exp) && cyc < 400) begin
            @(posedge clk);
            #1;
            in_valid  = exp_q.size() == 0 ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
            acc_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            fin_ready = 1'b0;
            fin_done  = 1'b0;
            if (phase == 1) begin
                fin_ready = stall >= fin_stall;
                stall++;
                fin_done = fin_ready && fin_lat == 0;
                cd = fin_lat;
            end else if (phase == 2) begin
                cd--;
                fin_done = cd == 0;
            end else if (rand_bp) begin
                fin_done = $urandom_range(0, 3) == 0;
            end
            @(negedge clk);
            n_vec++; if (in_ready !== (phase == 0 ? acc_ready : 1'b0)) begin n_err++; $display("FAIL %s in_ready cyc %0d got %b phase %0d", name, cyc, in_ready, phase); end
            n_vec++; if (acc_valid !== (phase == 0 ? in_valid : 1'b0)) begin n_err++; $display("FAIL %s acc_valid cyc %0d got %b phase %0d", name, cyc, acc_valid, phase); end
            n_vec++; if (fin_valid !== (phase == 1)) begin n_err++; $display("FAIL %s fin_valid cyc %0d got %b want %b", name, cyc, fin_valid, phase == 1); end
            n_vec++; if (frame_done !== fd_exp) begin n_err++; $display("FAIL %s frame_done cyc %0d got %b want %b", name, cyc, frame_done, fd_exp); end
            if (phase != 0) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy cyc %0d got %b want 1", name, cyc, busy); end
            end
            phase_n = phase;
            fd_next = 0;
            if (phase == 0 && in_valid && acc_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL %s extra_transfer cyc %0d got transfer want none", name, cyc);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++; if ({1'b0, channel} !== e.ch) begin n_err++; $display("FAIL %s xfer_channel got %0d want %0d", name, channel, e.ch); end
                    n_vec++; if (acc_first !== e.first) begin n_err++; $display("FAIL %s acc_first got %b want %b", name, acc_first, e.first); end
                    n_vec++; if (acc_last !== e.last) begin n_err++; $display("FAIL %s acc_last got %b want %b", name, acc_last, e.last); end
                    if (e.last) begin
                        phase_n = 1;
                        stall = 0;
                    end
                end
            end
            if (phase == 1 && fin_q.size() != 0) begin
                n_vec++; if (int'(channel) !== fin_q[0]) begin n_err++; $display("FAIL %s fin_channel got %0d want %0d", name, channel, fin_q[0]); end
                if (fin_ready) begin
                    cur = fin_q.pop_front();
                    phase_n = fin_done ? 0 : 2;
                    fd_next = fin_done && cur == 1;
                    if (fin_done && cur == 1) frames++;
                end
            end
            if (phase == 2 && fin_done) begin
                phase_n = 0;
                fd_next = cur == 1;
                if (cur == 1) frames++;
            end
            phase = phase_n;
            fd_exp = fd_next;
            cyc++;
        end
        if (cyc >= 400) begin
            n_vec++; n_err++; $display("FAIL %s timeout got %0d cycles want <400", name, cyc);
        end
        exp_q.delete();
        fin_q.delete();
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s end_busy got %b want 0", name, busy); end
        n_vec++; if (channel !== 1'b0) begin n_err++; $display("FAIL %s end_channel got %0d want 0", name, channel); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL %s end_frame_done got %b want 0", name, frame_done); end
        n_vec++; if (acc_first !== 1'b1) begin n_err++; $display("FAIL %s end_acc_first got %b want 1", name, acc_first); end
    endtask

    task automatic test_full_frame;
        run_frame("full_frame", 1'b0, 2, 0);
    endtask

    task automatic test_backpressure;
        run_frame("backpressure", 1'b1, 3, 2);
    endtask

    task automatic test_fin_stall;
        run_frame("fin_stall", 1'b0, 1, 5);
    endtask

    task automatic test_back_to_back;
        run_frame("same_cycle_done", 1'b0, 0, 0);
    endtask

    task automatic test_single_block;
        xfer_t q[$];
        bit    prev_x = 0, fd_exp = 0, fd_next;
        int    last_ch = 0, fd_cnt = 0, cyc = 0;
        xfer_t e;
        foreach (q[i]) q.delete(i);
        q.push_back('{ch: 2'd0, first: 1'b1, last: 1'b1});
        q.push_back('{ch: 2'd1, first: 1'b1, last: 1'b1});
        q.push_back('{ch: 2'd2, first: 1'b1, last: 1'b1});
        q.push_back('{ch: 2'd0, first: 1'b1, last: 1'b1});
        while ((q.size() != 0 || prev_x || fd_exp) && cyc < 40) begin
            @(posedge clk);
            #1;
            b_in_valid  = q.size() != 0;
            b_acc_ready = 1'b1;
            b_fin_ready = 1'b1;
            b_fin_done  = 1'b1;
            @(negedge clk);
            n_vec++; if (b_fin_valid !== prev_x) begin n_err++; $display("FAIL single fin_valid cyc %0d got %b want %b", cyc, b_fin_valid, prev_x); end
            n_vec++; if (b_frame_done !== fd_exp) begin n_err++; $display("FAIL single frame_done cyc %0d got %b want %b", cyc, b_frame_done, fd_exp); end
            if (b_frame_done === 1'b1) fd_cnt++;
            fd_next = prev_x && last_ch == 2;
            prev_x = 0;
            if (b_in_valid && b_in_ready) begin
                e = q.pop_front();
                n_vec++; if (b_channel !== e.ch) begin n_err++; $display("FAIL single channel got %0d want %0d", b_channel, e.ch); end
                n_vec++; if ({b_acc_first, b_acc_last} !== 2'b11) begin n_err++; $display("FAIL single first_last got %b%b want 11", b_acc_first, b_acc_last); end
                last_ch = e.ch;
                prev_x = 1;
            end
            fd_exp = fd_next;
            cyc++;
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (cyc >= 40) begin n_err++; $display("FAIL single timeout got %0d cycles want <40", cyc); end
        n_vec++; if (fd_cnt !== 1) begin n_err++; $display("FAIL single frame_done_count got %0d want 1", fd_cnt); end
        n_vec++; if (b_channel !== 2'd1) begin n_err++; $display("FAIL single end_channel got %0d want 1", b_channel); end
        {b_acc_ready, b_fin_ready, b_fin_done} = '0;
    endtask

    task automatic test_reset_mid;
        repeat (4) drv(1'b1, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        n_vec++; if ({fin_valid, channel} !== 2'b10) begin n_err++; $display("FAIL rst_mid ch0_request got %b%b want 10", fin_valid, channel); end
        drv(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if ({channel, acc_first} !== 2'b11) begin n_err++; $display("FAIL rst_mid ch1_start got %b%b want 11", channel, acc_first); end
        repeat (3) drv(1'b1, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++; if ({fin_valid, in_ready, busy, channel} !== 4'b0011) begin n_err++; $display("FAIL rst_mid fin_wait got %b want 0011", {fin_valid, in_ready, busy, channel}); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        fin_done = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fin_done = 1'b0;
        @(negedge clk);
        n_vec++; if (fin_valid !== 1'b0)  begin n_err++; $display("FAIL rst_mid fin_valid got %b want 0", fin_valid); end
        n_vec++; if (channel !== 1'b0)    begin n_err++; $display("FAIL rst_mid channel got %0d want 0", channel); end
        n_vec++; if (acc_first !== 1'b1)  begin n_err++; $display("FAIL rst_mid acc_first got %b want 1", acc_first); end
        n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_mid busy got %b want 0", busy); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_mid frame_done got %b want 0", frame_done); end
        @(negedge clk);
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_mid frame_done_late got %b want 0", frame_done); end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_backpressure;
        test_fin_stall;
        test_back_to_back;
        test_single_block;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
